// File: rtl/irq_controller_if.sv
// Bus bundle between a CPU-side master and the interrupt controller.
// reg_we and irq_ack are single-cycle strobes sampled on posedge clk and accepted unconditionally (no back-pressure); outputs are valid every cycle.
interface irq_controller_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] src;
  logic               reg_we;
  logic [1:0]         reg_addr;
  logic [7:0]         reg_wdata;
  logic [7:0]         reg_rdata;
  logic               irq_ack;
  logic               irq;
  logic [2:0]         irq_id;

  modport master (
    output src, reg_we, reg_addr, reg_wdata, irq_ack,
    input  reg_rdata, irq, irq_id
  );

  modport slave (
    input  src, reg_we, reg_addr, reg_wdata, irq_ack,
    output reg_rdata, irq, irq_id
  );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: edge-detected sources, ENABLE/PENDING/VECTOR/CONFIG
// registers, and a pulse/level irq line serviced by a three-state FSM.
module irq_controller #(
  parameter int NUM_SRC   = 4,
  parameter int DEF_PULSE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  irq_controller_if.slave   bus,
  output logic [1:0]        o_dbg_state
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_VECTOR  = 2'd2;
  localparam logic [1:0] ADDR_CONFIG  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_enable;
  logic [7:0] r_pending;
  logic [7:0] r_src_q;
  logic       r_armed;
  logic [3:0] r_pulse_len;
  logic [3:0] r_cnt;
  logic       r_irq;
  logic [2:0] r_irq_id;

  logic [7:0] w_src8;
  logic [7:0] w_edge;
  logic       w_wr_enable;
  logic       w_wr_pending;
  logic       w_wr_config;
  logic       w_busy;
  logic [7:0] w_ack_clr;
  logic [7:0] w_clr;
  logic [7:0] w_pend_nxt;
  logic [7:0] w_en_nxt;
  logic [7:0] w_active;
  logic       w_vld;
  logic [2:0] w_win_id;
  logic [7:0] w_vector;
  logic [7:0] w_rdata;
  logic       w_drop;

  assign w_src8 = 8'(bus.src) & SRC_MASK;

  // src_q resets to 0, so the first cycle after reset would see any held-high
  // source as a fresh edge; r_armed suppresses detection for that one cycle.
  assign w_edge = r_armed ? (w_src8 & ~r_src_q) : 8'd0;

  assign w_wr_enable  = bus.reg_we && (bus.reg_addr == ADDR_ENABLE);
  assign w_wr_pending = bus.reg_we && (bus.reg_addr == ADDR_PENDING);
  assign w_wr_config  = bus.reg_we && (bus.reg_addr == ADDR_CONFIG);

  assign w_busy    = (r_state == ST_ASSERT) || (r_state == ST_WAIT_ACK);
  assign w_ack_clr = (w_busy && bus.irq_ack) ? (8'd1 << r_irq_id) : 8'd0;
  assign w_clr     = (w_wr_pending ? bus.reg_wdata : 8'd0) | w_ack_clr;

  // A new edge wins over any clear of the same bit in the same cycle.
  assign w_pend_nxt = ((r_pending & ~w_clr) | w_edge) & SRC_MASK;
  assign w_en_nxt   = w_wr_enable ? (bus.reg_wdata & SRC_MASK) : r_enable;

  assign w_active = r_pending & r_enable;

  always_comb begin
    w_vld    = 1'b0;
    w_win_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_active[i]) begin
        w_vld    = 1'b1;
        w_win_id = 3'(i);
      end
    end
  end

  assign w_vector = {w_vld, 4'b0000, w_win_id};

  always_comb begin
    w_rdata = 8'd0;
    case (bus.reg_addr)
      ADDR_ENABLE:  w_rdata = r_enable;
      ADDR_PENDING: w_rdata = r_pending;
      ADDR_VECTOR:  w_rdata = w_vector;
      ADDR_CONFIG:  w_rdata = {4'b0000, r_pulse_len};
      default:      w_rdata = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enable    <= 8'd0;
      r_pending   <= 8'd0;
      r_src_q     <= 8'd0;
      r_armed     <= 1'b0;
      r_pulse_len <= 4'(DEF_PULSE);
    end else begin
      r_src_q   <= w_src8;
      r_armed   <= 1'b1;
      r_pending <= w_pend_nxt;
      r_enable  <= w_en_nxt;
      if (w_wr_config) begin
        r_pulse_len <= bus.reg_wdata[3:0];
      end
    end
  end

  // Service ends on ack, or when software removes the serviced source's
  // pending or enable bit; a simultaneous new edge keeps the bit set.
  assign w_drop = bus.irq_ack || !w_pend_nxt[r_irq_id] || !w_en_nxt[r_irq_id];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_irq    <= 1'b0;
      r_irq_id <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            r_state  <= ST_ASSERT;
            r_irq    <= 1'b1;
            r_irq_id <= w_win_id;
            r_cnt    <= r_pulse_len;
          end
        end
        ST_ASSERT, ST_WAIT_ACK: begin
          if (w_drop) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_cnt   <= 4'd0;
          end else if ((r_state == ST_ASSERT) && (r_cnt != 4'd0)) begin
            // A zero count means level mode: hold until ack.
            if (r_cnt == 4'd1) begin
              r_state <= ST_WAIT_ACK;
              r_irq   <= 1'b0;
              r_cnt   <= 4'd0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.irq       = r_irq;
  assign bus.irq_id    = r_irq_id;
  assign bus.reg_rdata = w_rdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register/pulse vector table, hand-written corner
// sequences, and randomized traffic against a rule-level reference model.
module tb_irq_controller;

  localparam int         NUM_SRC   = 4;
  localparam int         DEF_PULSE = 3;
  localparam logic [7:0] MASK      = 8'h0F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  irq_controller_if #(.NUM_SRC(NUM_SRC)) bus ();

  irq_controller #(.NUM_SRC(NUM_SRC), .DEF_PULSE(DEF_PULSE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.reg_we    = 1'b0;
    bus.reg_addr  = 2'd0;
    bus.reg_wdata = 8'd0;
    bus.irq_ack   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.src = '0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    step();
    bus.reg_we    = 1'b0;
    bus.reg_wdata = 8'd0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    bus.reg_addr = a;
    #1;
    check(name, bus.reg_rdata, exp);
  endtask

  task automatic wait_irq(input string name, input int max_cyc);
    int n;
    n = 0;
    while (bus.irq !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check(name, bus.irq, 1);
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 = not servicing, 1 = line high, 2 = waiting for ack.
  logic [7:0] m_en, m_pend, m_srcq;
  logic [3:0] m_plen;
  logic       m_armed;
  int         m_phase, m_id, m_len, m_high;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_srcq = 0; m_plen = 4'(DEF_PULSE); m_armed = 0;
    m_phase = 0; m_id = 0; m_len = 0; m_high = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    logic [7:0] act;
    act = m_pend & m_en;
    case (a)
      2'd0:    return m_en;
      2'd1:    return m_pend;
      2'd2:    return (act != 0) ? (8'h80 | 8'(lowest(act))) : 8'h00;
      default: return {4'h0, m_plen};
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic we, input logic [1:0] a,
                            input logic [7:0] d, input logic [3:0] src, input logic ack);
    logic [7:0] edges, clr, n_pend, n_en, act;
    if (!rst) begin
      model_reset();
      return;
    end
    edges = m_armed ? ({4'h0, src} & ~m_srcq) : 8'h00;
    clr   = (we && a == 2'd1) ? d : 8'h00;
    if (m_phase != 0 && ack) clr[m_id] = 1'b1;
    n_pend = ((m_pend & ~clr) | edges) & MASK;
    n_en   = (we && a == 2'd0) ? (d & MASK) : m_en;
    act    = m_pend & m_en;
    if (m_phase == 0) begin
      if (act != 0) begin
        m_id = lowest(act); m_phase = 1; m_len = int'(m_plen); m_high = 1;
      end
    end else if (ack || !n_pend[m_id] || !n_en[m_id]) begin
      m_phase = 0;
    end else if (m_phase == 1 && m_len != 0) begin
      if (m_high == m_len) m_phase = 2;
      else m_high++;
    end
    if (we && a == 2'd3) m_plen = d[3:0];
    m_pend = n_pend; m_en = n_en; m_srcq = {4'h0, src}; m_armed = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [3:0] src;
    logic       ack;
    logic       exp_irq;
    logic [2:0] exp_id;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt[15];

  initial begin
    int hi_cnt;
    logic [1:0] ra;
    vt[0]  = '{1'b0, 2'd3, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'h03};
    vt[1]  = '{1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'h00};
    vt[2]  = '{1'b1, 2'd0, 8'hFF, 4'h0, 1'b0, 1'b0, 3'd0, 8'h00};
    vt[3]  = '{1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'h0F};
    vt[4]  = '{1'b1, 2'd0, 8'h01, 4'h0, 1'b0, 1'b0, 3'd0, 8'h0F};
    vt[5]  = '{1'b0, 2'd3, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'h03};
    vt[6]  = '{1'b0, 2'd1, 8'h00, 4'h1, 1'b0, 1'b0, 3'd0, 8'h00};
    vt[7]  = '{1'b0, 2'd1, 8'h00, 4'h1, 1'b0, 1'b0, 3'd0, 8'h01};
    vt[8]  = '{1'b0, 2'd2, 8'h00, 4'h1, 1'b0, 1'b1, 3'd0, 8'h80};
    vt[9]  = '{1'b0, 2'd1, 8'h00, 4'h1, 1'b0, 1'b1, 3'd0, 8'h01};
    vt[10] = '{1'b1, 2'd3, 8'h05, 4'h1, 1'b0, 1'b1, 3'd0, 8'h03};
    vt[11] = '{1'b0, 2'd3, 8'h00, 4'h1, 1'b0, 1'b0, 3'd0, 8'h05};
    vt[12] = '{1'b0, 2'd2, 8'h00, 4'h1, 1'b1, 1'b0, 3'd0, 8'h80};
    vt[13] = '{1'b0, 2'd1, 8'h00, 4'h1, 1'b0, 1'b0, 3'd0, 8'h00};
    vt[14] = '{1'b0, 2'd2, 8'h00, 4'h1, 1'b0, 1'b0, 3'd0, 8'h00};

    // Pulse of three cycles on src[0], CONFIG write mid-pulse, ack in WAIT_ACK.
    do_reset();
    check("reset_state", dbg_state, 0);
    for (int i = 0; i < 15; i++) begin
      bus.src       = vt[i].src;
      bus.reg_we    = vt[i].we;
      bus.reg_addr  = vt[i].addr;
      bus.reg_wdata = vt[i].wdata;
      bus.irq_ack   = vt[i].ack;
      #1;
      check($sformatf("vec%0d_irq", i), bus.irq, vt[i].exp_irq);
      check($sformatf("vec%0d_id", i), bus.irq_id, vt[i].exp_id);
      check($sformatf("vec%0d_rd", i), bus.reg_rdata, vt[i].exp_rd);
      step();
    end
    idle_inputs();

    // Simultaneous edges: lower index first, the other right after ack.
    do_reset();
    wr(2'd0, 8'h0F);
    bus.src = 4'b0110;
    step();
    rd_check("prio_pending", 2'd1, 8'h06);
    step();
    check("prio_irq1", bus.irq, 1);
    check("prio_id1", bus.irq_id, 1);
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    check("prio_ack_irq", bus.irq, 0);
    check("prio_ack_idle", dbg_state, 0);
    rd_check("prio_ack_pending", 2'd1, 8'h04);
    step();
    check("prio_irq2", bus.irq, 1);
    check("prio_id2", bus.irq_id, 2);
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;

    // Level mode held for 20 cycles until ack.
    do_reset();
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h08);
    bus.src = 4'b1000;
    step();
    wait_irq("level_rise", 5);
    check("level_id", bus.irq_id, 3);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.irq === 1'b1) hi_cnt++;
      step();
    end
    check("level_hold", hi_cnt, 20);
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    check("level_ack_irq", bus.irq, 0);
    rd_check("level_ack_pending", 2'd1, 8'h00);

    // Set beats W1C on the same bit; ack in IDLE is ignored.
    do_reset();
    step();
    bus.src = 4'b0001;
    step();
    bus.src = 4'b0000;
    step();
    rd_check("w1c_pre", 2'd1, 8'h01);
    bus.src = 4'b0001;
    wr(2'd1, 8'h01);
    rd_check("w1c_vs_edge", 2'd1, 8'h01);
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    rd_check("idle_ack_pending", 2'd1, 8'h01);
    check("idle_ack_state", dbg_state, 0);
    check("idle_ack_irq", bus.irq, 0);
    wr(2'd1, 8'h01);
    rd_check("w1c_plain", 2'd1, 8'h00);

    // Reset mid-pulse with src held high across reset release.
    do_reset();
    wr(2'd0, 8'h01);
    bus.src = 4'b0001;
    step();
    wait_irq("rst_mid_rise", 4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_irq", bus.irq, 0);
    check("rst_mid_id", bus.irq_id, 0);
    rd_check("rst_mid_enable", 2'd0, 8'h00);
    rd_check("rst_mid_pending", 2'd1, 8'h00);
    step();
    rd_check("rst_mid_config", 2'd3, 8'(DEF_PULSE));
    rd_check("rst_mid_vector", 2'd2, 8'h00);
    step();
    step();
    rd_check("held_src_no_edge", 2'd1, 8'h00);
    bus.src = 4'b0000;
    step();
    bus.src = 4'b0001;
    step();
    rd_check("held_src_rearm", 2'd1, 8'h01);

    // Pending while disabled, then enable.
    do_reset();
    step();
    bus.src = 4'b0010;
    step();
    step();
    rd_check("dis_pending", 2'd1, 8'h02);
    check("dis_no_irq", bus.irq, 0);
    step();
    check("dis_no_irq2", bus.irq, 0);
    wr(2'd0, 8'h02);
    wait_irq("dis_enable_irq", 2);
    check("dis_enable_id", bus.irq_id, 1);

    // Software withdraws the serviced source.
    do_reset();
    wr(2'd0, 8'h01);
    bus.src = 4'b0001;
    step();
    wait_irq("sw_clr_rise", 4);
    wr(2'd1, 8'h01);
    check("sw_clr_irq", bus.irq, 0);
    check("sw_clr_state", dbg_state, 0);
    bus.src = 4'b0000;
    step();
    bus.src = 4'b0001;
    step();
    wait_irq("sw_dis_rise", 4);
    wr(2'd0, 8'h00);
    check("sw_dis_irq", bus.irq, 0);
    check("sw_dis_state", dbg_state, 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] flip;
      rst_n = ($urandom_range(0, 299) != 0);
      for (int b = 0; b < NUM_SRC; b++) flip[b] = ($urandom_range(0, 5) == 0);
      bus.src       = bus.src ^ flip;
      bus.reg_we    = ($urandom_range(0, 7) == 0);
      ra            = 2'($urandom_range(0, 3));
      bus.reg_addr  = ra;
      bus.reg_wdata = (ra == 2'd3) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      bus.irq_ack   = ($urandom_range(0, 5) == 0);
      #1;
      check("rnd_irq", bus.irq, (m_phase == 1) ? 1 : 0);
      check("rnd_id", bus.irq_id, (m_phase == 0 && c == 0) ? 0 : 3'(m_id));
      check("rnd_rdata", bus.reg_rdata, model_read(ra));
      @(posedge clk);
      model_step(rst_n, bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.src, bus.irq_ack);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
